// File: rtl/hatch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hatch_ctrl
// Purpose  : Run controller for the egg-hatch second counter (start/pause/abort,
//            target compare, timed buzzer, hatched indication).
// Revision : 1.0 - initial release
// ============================================================================
module hatch_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int ALARM_SEC = 5,
    parameter int W         = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_start,
    input  logic         key_pause,
    input  logic         key_clr,
    input  logic [W-1:0] cfg_target,
    input  logic [W-1:0] cnt_num,
    output logic         cnt_st,
    output logic         cnt_clr,
    output logic [2:0]   state,
    output logic [W-1:0] remaining,
    output logic         buzzer,
    output logic         hatched,
    output logic         err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_PAUSE = 3'd2;
    localparam logic [2:0] c_ALARM = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam int            c_PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [3:0]    c_SEC_LAST = 4'(ALARM_SEC - 1);

    // Key vectors are indexed 0=start, 1=pause, 2=clr.
    logic [2:0]      r_s0, r_s1, r_s2, r_arm;
    logic [1:0]      r_vld;
    logic [2:0]      w_ev;
    logic [2:0]      r_state, w_next;
    logic [W-1:0]    r_target;
    logic [c_PW-1:0] r_pre;
    logic [3:0]      r_sec;
    logic            r_cnt_st, r_cnt_clr, r_err;
    logic            w_clr_p, w_err_p, w_latch;
    logic [W-1:0]    w_rem;

    // A key only arms once it has been seen low after reset, so a key held
    // through reset release cannot fire a spurious event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0  <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_arm <= '0;
            r_vld <= '0;
        end else begin
            r_s0  <= {key_clr, key_pause, key_start};
            r_s1  <= r_s0;
            r_s2  <= r_s1;
            r_vld <= {r_vld[0], 1'b1};
            r_arm <= r_arm | ({3{r_vld[1]}} & ~r_s1);
        end
    end

    assign w_ev = r_s1 & ~r_s2 & r_arm;

    always_comb begin
        w_next  = r_state;
        w_clr_p = 1'b0;
        w_err_p = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (w_ev[0]) begin
                    if (cfg_target != '0) begin
                        w_next  = c_RUN;
                        w_clr_p = 1'b1;
                        w_latch = 1'b1;
                    end else begin
                        w_err_p = 1'b1;
                    end
                end
            end
            c_RUN: begin
                // While the clear pulse is out, cnt_num still shows the previous run.
                if (w_ev[1])
                    w_next = c_PAUSE;
                else if (!r_cnt_clr && (cnt_num >= r_target))
                    w_next = c_ALARM;
            end
            c_PAUSE: begin
                if (w_ev[0] || w_ev[1])
                    w_next = c_RUN;
            end
            c_ALARM: begin
                if (w_ev[0] || w_ev[1])
                    w_next = c_DONE;
                else if ((r_pre == c_PRE_MAX) && (r_sec == c_SEC_LAST))
                    w_next = c_DONE;
            end
            default: w_next = c_IDLE;
        endcase
        if (w_ev[2]) begin
            w_next  = c_IDLE;
            w_clr_p = 1'b1;
            w_err_p = 1'b0;
            w_latch = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_target  <= '0;
            r_cnt_st  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_err     <= 1'b0;
            r_pre     <= '0;
            r_sec     <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt_clr <= w_clr_p;
            r_err     <= w_err_p;
            // Run-enable rises one cycle after RUN entry, never alongside cnt_clr.
            r_cnt_st  <= (r_state == c_RUN) && (w_next == c_RUN);
            if (w_latch)
                r_target <= cfg_target;
            if ((w_next == c_ALARM) && (r_state != c_ALARM)) begin
                r_pre <= '0;
                r_sec <= '0;
            end else if (r_state == c_ALARM) begin
                if (r_pre == c_PRE_MAX) begin
                    r_pre <= '0;
                    r_sec <= r_sec + 4'd1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rem = '0;
        if ((r_state == c_RUN) || (r_state == c_PAUSE)) begin
            if (r_cnt_clr)
                w_rem = r_target;
            else if (cnt_num < r_target)
                w_rem = r_target - cnt_num;
        end
    end

    assign cnt_st    = r_cnt_st;
    assign cnt_clr   = r_cnt_clr;
    assign err       = r_err;
    assign state     = r_state;
    assign remaining = w_rem;
    assign buzzer    = (r_state == c_ALARM);
    assign hatched   = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: doc/hatch_ctrl.md
Name: hatch_ctrl

Overview:
Run controller for the egg-hatch second counter. It takes the start, pause and abort keys and a preset hatch time. It drives the counter's run-enable and clear inputs and compares the counter's second count against the target. On expiry it sounds a timed buzzer and holds a "hatched" indication until the next run or an abort.

Parameters:
TICK_DIV, 1000, clk cycles per second for the internal alarm-duration prescaler (1 kHz clk)
ALARM_SEC, 5, buzzer duration in seconds, range 1..15
W, 5, width of the second count and target

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset; all registers cleared while low
key_start  in  1  start/resume key, level, asynchronous to clk, already debounced
key_pause  in  1  pause key, level, asynchronous, debounced
key_clr  in  1  abort key, level, asynchronous, debounced
cfg_target  in  W  hatch time in seconds
cnt_num  in  W  second count returned by the counter
cnt_st  out  1  counter run-enable (1 = count)
cnt_clr  out  1  counter clear, active-high one-cycle pulse
state  out  3  IDLE=0, RUN=1, PAUSE=2, ALARM=3, DONE=4
remaining  out  W  seconds left to hatch
buzzer  out  1  alarm drive
hatched  out  1  hatch complete indicator
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset values: state=IDLE, cnt_st=0, cnt_clr=0, buzzer=0, hatched=0, err=0, target register=0, prescaler=0, second counter=0.
- Key inputs:
  - Each key passes through a 2-flop synchroniser, then a rising-edge detector.
  - The edge detector produces one 1-cycle event per press.
  - Event latency: 3 clk from key rise to event.
  - Holding a key produces no repeat events.
- Key priority within a single cycle: clr > pause > start.
- IDLE:
  - start with cfg_target!=0: latch cfg_target into target_q, pulse cnt_clr for 1 cycle, go to RUN.
  - start with cfg_target==0: stay in IDLE and pulse err for 1 cycle.
  - pause is ignored.
- RUN:
  - cnt_st=1.
  - pause event goes to PAUSE.
  - start is ignored.
  - If cnt_num >= target_q: go to ALARM. cnt_st is 0 from the cycle after cnt_num first satisfies the compare (1-cycle latency).
- PAUSE:
  - cnt_st=0 and cnt_num is held.
  - start or pause event goes to RUN.
  - cfg_target changes are not sampled.
- ALARM:
  - cnt_st=0, buzzer=1.
  - On entry the prescaler and second counter are cleared.
  - The prescaler counts 0..TICK_DIV-1; each wrap increments the second counter.
  - When the second counter reaches ALARM_SEC: go to DONE and drop buzzer.
  - A start or pause event goes to DONE immediately (silence).
- DONE:
  - hatched=1, cnt_st=0; cnt_num is left frozen at its final value.
  - A start event behaves as start from IDLE, including the cfg_target==0 rejection, which keeps the block in DONE.
- clr event in any state:
  - Go to IDLE, pulse cnt_clr for 1 cycle, clear hatched and buzzer.
  - clr in IDLE still pulses cnt_clr.
- remaining:
  - RUN/PAUSE: target_q - cnt_num, saturating at 0 when cnt_num >= target_q.
  - All other states: 0.
  - Combinational from registered values.
- cnt_clr and cnt_st are registered outputs; cnt_clr is never high in the same cycle as a cnt_st rising edge.
- Asynchronous reset low mid-run: all outputs return to reset values immediately. No cnt_clr is issued; the counter has its own reset.
- Only the compare result is used, so counter wrap (31→0) cannot occur before ALARM for any legal target ≤ 31.
- State encodings 5..7 are unreachable; if entered they recover to IDLE on the next clk.

Test Plan:
Bench settings: TICK_DIV=4, ALARM_SEC=3, counter model increments cnt_num every 8 clk while cnt_st=1.
1. cfg_target=3, press start: cnt_clr pulses 1 cycle, state=RUN, remaining 3→2→1. On cnt_num=3, state=ALARM one cycle later and cnt_st=0. buzzer high for exactly 12 clk, then state=DONE, hatched=1.
2. Run with target=5; press pause at cnt_num=2: cnt_st=0, remaining=3 held for 100 clk. Press start: RUN resumes and ALARM is reached at cnt_num=5.
3. cfg_target=0, press start from IDLE: err pulses 1 cycle, state stays IDLE, cnt_st=0, no cnt_clr.
4. Assert clr+pause+start in the same cycle while in RUN: state=IDLE, cnt_clr pulses once, no PAUSE entry.
5. Silence and restart: in ALARM, press pause after 5 clk: buzzer drops, state=DONE. Set cfg_target=2 and press start: cnt_clr pulses, hatched=0, RUN, target_q=2.
6. Pull rst low asynchronously mid-RUN, between clk edges: cnt_st, buzzer and state clear without waiting for a clk edge. Hold key_start high through reset release: no start event is generated.
